// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: transmitter FSM encodings, debug view, odd parity helper
// and the keyboard command bytes the Apple 1 side sends.
package ps2_defs;

  localparam int TIMER_W = 19;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_FIRST,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE
  } ps2_state_t;

  typedef struct packed {
    ps2_state_t  state;
    logic [3:0]  bit_idx;
    logic        clk_sync;
    logic        din_sync;
    logic        din_fall;
  } ps2_dbg_t;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one asynchronous PS/2 line plus a falling-edge
// detector on the synchronized level. Lines idle high, so reset loads ones.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta;
  logic cur;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      cur  <= meta;
      prev <= cur;
    end
  end

  assign line_sync = cur;
  assign fall      = prev & ~cur;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send, then
// shifts a start/data/parity/stop frame on device-generated falling clock edges.
module ps2_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES     = 3000,
  parameter int FIRST_EDGE_TIMEOUT = 375000,
  parameter int EDGE_TIMEOUT       = 50000
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_din_in,
  output logic       ps2_clk_oe,
  output logic       ps2_din_oe,
  output ps2_dbg_t   dbg
);

  // Handshake: a byte is taken on any clk25 edge where tx_valid & tx_ready;
  // tx_ready is high only in IDLE, so requests raised while busy simply wait.

  localparam logic [TIMER_W-1:0] INHIBIT_LOAD = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FIRST_LOAD   = TIMER_W'(FIRST_EDGE_TIMEOUT);
  localparam logic [TIMER_W-1:0] EDGE_LOAD    = TIMER_W'(EDGE_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  ps2_state_t         state, state_n;
  logic [10:0]        frame, frame_n;
  logic [3:0]         bit_idx, bit_idx_n;
  logic [TIMER_W-1:0] timer, timer_n;

  logic clk_sync, clk_fall;
  logic din_sync, din_fall;
  logic timer_zero;

  ps2_line_sync u_clk_sync (
    .clk       (clk25),
    .rst_n     (rst_n),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .fall      (clk_fall)
  );

  ps2_line_sync u_din_sync (
    .clk       (clk25),
    .rst_n     (rst_n),
    .line_in   (ps2_din_in),
    .line_sync (din_sync),
    .fall      (din_fall)
  );

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      frame   <= '1;
      bit_idx <= '0;
      timer   <= '0;
    end else begin
      state   <= state_n;
      frame   <= frame_n;
      bit_idx <= bit_idx_n;
      timer   <= timer_n;
    end
  end

  assign timer_zero = (timer == '0);

  // Outputs decode from the state register so an async reset drops the lines at once.
  always_comb begin
    state_n    = state;
    frame_n    = frame;
    bit_idx_n  = bit_idx;
    timer_n    = timer;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_din_oe = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          frame_n   = {1'b1, ps2_odd_parity(tx_data), tx_data, 1'b0};
          bit_idx_n = '0;
          timer_n   = INHIBIT_LOAD;
          state_n   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (timer_zero) state_n = ST_REQ;
        else            timer_n = timer - TIMER_ONE;
      end
      ST_REQ: begin
        ps2_clk_oe = 1'b1;
        ps2_din_oe = ~frame[bit_idx];
        timer_n    = FIRST_LOAD;
        state_n    = ST_WAIT_FIRST;
      end
      ST_WAIT_FIRST, ST_SHIFT: begin
        ps2_din_oe = ~frame[bit_idx];
        if (clk_fall) begin
          bit_idx_n = bit_idx + 4'd1;
          timer_n   = EDGE_LOAD;
          if (state == ST_WAIT_FIRST) state_n = ST_SHIFT;
          else if (bit_idx == 4'd9)   state_n = ST_ACK;
        end else if (timer_zero) begin
          tx_error = 1'b1;
          state_n  = ST_IDLE;
        end else begin
          timer_n = timer - TIMER_ONE;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          timer_n = EDGE_LOAD;
          if (!din_sync) begin
            state_n = ST_RELEASE;
          end else begin
            tx_error = 1'b1;
            state_n  = ST_IDLE;
          end
        end else if (timer_zero) begin
          tx_error = 1'b1;
          state_n  = ST_IDLE;
        end else begin
          timer_n = timer - TIMER_ONE;
        end
      end
      ST_RELEASE: begin
        if (clk_sync && din_sync) begin
          tx_done = 1'b1;
          state_n = ST_IDLE;
        end else if (timer_zero) begin
          tx_error = 1'b1;
          state_n  = ST_IDLE;
        end else begin
          timer_n = timer - TIMER_ONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  assign dbg.state    = state;
  assign dbg.bit_idx  = bit_idx;
  assign dbg.clk_sync = clk_sync;
  assign dbg.din_sync = din_sync;
  assign dbg.din_fall = din_fall;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the host, a
// scoreboard holds the expected 11-bit frames, each scenario checks inline.
module tb_ps2_tx;
  import ps2_defs::*;

  localparam int HALF = 100;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_oe, ps2_din_oe;
  ps2_dbg_t   dbg;

  logic dev_clk_low = 1'b0;
  logic dev_din_low = 1'b0;
  wire  clk_line = ~(ps2_clk_oe | dev_clk_low);
  wire  din_line = ~(ps2_din_oe | dev_din_low);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, inh_cnt = 0;
  int err_cyc = 0, last_fall = 0;

  logic [10:0] exp_q[$];

  ps2_tx #(
    .INHIBIT_CYCLES     (100),
    .FIRST_EDGE_TIMEOUT (2000),
    .EDGE_TIMEOUT       (500)
  ) dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_in (clk_line),
    .ps2_din_in (din_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_din_oe (ps2_din_oe),
    .dbg        (dbg)
  );

  // clock / reset
  always #5 clk25 = ~clk25;
  always @(posedge clk25) cyc = cyc + 1;

  // pulse monitor
  always @(negedge clk25) begin
    if (tx_done) done_cnt = done_cnt + 1;
    if (tx_error) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (ps2_clk_oe && !ps2_din_oe) inh_cnt = inh_cnt + 1;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    @(negedge clk25);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 5000) begin
      @(negedge clk25);
      n++;
    end
    checks++;
    if (!tx_ready) begin
      failures++;
      $display("FAIL send_accept got ready=%0b required 1", tx_ready);
    end
    @(negedge clk25);
    tx_valid = 1'b0;
  endtask

  // Device: waits for the request-to-send, then produces n_edges clock pulses,
  // sampling the data line on each rising edge; ACK pulls data low on clock 11.
  task automatic device_frame(input int n_edges, input bit ack, output logic [10:0] bits);
    int n = 0;
    logic [10:0] exp;
    bits = '1;
    while (!(busy && !ps2_clk_oe && ps2_din_oe) && n < 1000) begin
      @(negedge clk25);
      n++;
    end
    checks++;
    if (!(busy && !ps2_clk_oe && ps2_din_oe)) begin
      failures++;
      $display("FAIL request_seen got clk_oe=%0b din_oe=%0b required 0/1", ps2_clk_oe, ps2_din_oe);
      return;
    end
    repeat (20) @(negedge clk25);
    bits[0] = din_line;
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11 && ack) dev_din_low = 1'b1;
      dev_clk_low = 1'b1;
      last_fall = cyc;
      repeat (HALF) @(negedge clk25);
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i] = din_line;
      if (i == 11) dev_din_low = 1'b0;
      if (i != n_edges) repeat (HALF) @(negedge clk25);
    end
    if (n_edges == 11) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty got frame=%03h required none", bits);
      end else begin
        exp = exp_q.pop_front();
        if (bits !== exp) begin
          failures++;
          $display("FAIL frame_bits got=%03h required=%03h", bits, exp);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk25);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s_idle_timeout got busy=1 required 0", name);
    end
  endtask

  task automatic check_idle_lines(input string name);
    @(negedge clk25);
    checks++;
    if ({ps2_clk_oe, ps2_din_oe, tx_ready, busy} !== 4'b0010) begin
      failures++;
      $display("FAIL %s_idle got clk_oe/din_oe/ready/busy=%b required 0010", name,
               {ps2_clk_oe, ps2_din_oe, tx_ready, busy});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk25);
    rst_n = 1'b1;
    @(negedge clk25);
    checks++;
    if ({ps2_clk_oe, ps2_din_oe, tx_ready, tx_done, tx_error, busy} !== 6'b001000) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=001000",
               {ps2_clk_oe, ps2_din_oe, tx_ready, tx_done, tx_error, busy});
    end
    checks++;
    if (dbg.state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d required=%0d", dbg.state, ST_IDLE);
    end
  endtask

  task automatic test_send_ed();
    logic [10:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    exp_q.push_back(frame_of(CMD_SET_LEDS));
    send_byte(CMD_SET_LEDS);
    device_frame(11, 1'b1, bits);
    wait_idle("ed");
    checks++;
    if (bits !== 11'b11111011010) begin
      failures++;
      $display("FAIL ed_literal got=%03h required=%03h", bits, 11'b11111011010);
    end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      failures++;
      $display("FAIL ed_pulses got done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
    end
    check_idle_lines("ed");
  endtask

  task automatic test_send_f4();
    logic [10:0] bits;
    int d0 = done_cnt;
    inh_cnt = 0;
    exp_q.push_back(frame_of(CMD_ENABLE));
    send_byte(CMD_ENABLE);
    device_frame(11, 1'b1, bits);
    wait_idle("f4");
    checks++;
    if (bits[9] !== 1'b0) begin
      failures++;
      $display("FAIL f4_parity got=%0b required=0", bits[9]);
    end
    checks++;
    if (inh_cnt != 100) begin
      failures++;
      $display("FAIL f4_inhibit_len got=%0d required=100", inh_cnt);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL f4_done got=%0d required=1", done_cnt - d0);
    end
  endtask

  task automatic test_first_timeout();
    int n = 0, rel = 0, e0 = err_cnt, d0 = done_cnt;
    send_byte(8'h55);
    while (!(busy && !ps2_clk_oe) && n < 500) begin
      @(negedge clk25);
      n++;
    end
    rel = cyc;
    n = 0;
    while (err_cnt == e0 && n < 3000) begin
      @(negedge clk25);
      n++;
    end
    checks++;
    if (err_cnt - e0 != 1 || err_cyc - rel != 2000) begin
      failures++;
      $display("FAIL first_timeout got errors=%0d delay=%0d required 1/2000", err_cnt - e0, err_cyc - rel);
    end
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL first_timeout_done got=%0d required=0", done_cnt - d0);
    end
    check_idle_lines("first_timeout");
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    exp_q.push_back(frame_of(8'h3C));
    send_byte(8'h3C);
    device_frame(11, 1'b0, bits);
    wait_idle("no_ack");
    checks++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      failures++;
      $display("FAIL no_ack got err=%0d done=%0d required 1/0", err_cnt - e0, done_cnt - d0);
    end
    check_idle_lines("no_ack");
  endtask

  task automatic test_edge_timeout();
    logic [10:0] bits;
    int n = 0, e0 = err_cnt;
    send_byte(8'hA7);
    device_frame(5, 1'b0, bits);
    while (err_cnt == e0 && n < 1000) begin
      @(negedge clk25);
      n++;
    end
    // 3 cycles of synchronizer/edge latency, then the 500-cycle edge timer.
    checks++;
    if (err_cnt - e0 != 1 || err_cyc - last_fall != 503) begin
      failures++;
      $display("FAIL edge_timeout got errors=%0d delay=%0d required 1/503", err_cnt - e0, err_cyc - last_fall);
    end
    check_idle_lines("edge_timeout");
  endtask

  task automatic test_reset_mid_shift();
    logic [10:0] bits;
    send_byte(8'h81);
    device_frame(3, 1'b0, bits);
    @(negedge clk25);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_din_oe, busy, tx_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid_shift got clk_oe/din_oe/busy/ready=%b required 0001",
               {ps2_clk_oe, ps2_din_oe, busy, tx_ready});
    end
    @(negedge clk25);
    rst_n = 1'b1;
    repeat (5) @(negedge clk25);
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    int n = 0;
    exp_q.push_back(frame_of(CMD_RESET));
    exp_q.push_back(frame_of(CMD_ENABLE));
    @(negedge clk25);
    tx_data  = CMD_RESET;
    tx_valid = 1'b1;
    @(negedge clk25);
    tx_data = CMD_ENABLE;
    device_frame(11, 1'b1, bits);
    checks++;
    if (bits[9] !== 1'b1) begin
      failures++;
      $display("FAIL ff_parity got=%0b required=1", bits[9]);
    end
    while (!tx_done && n < 100) begin
      @(negedge clk25);
      n++;
    end
    @(negedge clk25);
    checks++;
    if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_after_done got ready=%0b clk_oe=%0b required 1/0", tx_ready, ps2_clk_oe);
    end
    @(negedge clk25);
    tx_valid = 1'b0;
    checks++;
    if (ps2_clk_oe !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_accept got clk_oe=%0b busy=%0b required 1/1", ps2_clk_oe, busy);
    end
    device_frame(11, 1'b1, bits);
    wait_idle("b2b");
    check_idle_lines("b2b");
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_f4();
    test_first_timeout();
    test_no_ack();
    test_edge_timeout();
    test_reset_mid_shift();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the Apple 1 system to the attached keyboard over the shared open-drain PS/2 clock/data lines. It is the transmit counterpart of the PS/2 keyboard receiver. It sits beside the receiver in the clk25 domain and drives the pins low through `_oe` outputs that feed the board SB_IO tristates. `busy` tells the receiver to ignore line activity.

## Interface
- `INHIBIT_CYCLES`, 3000: cycles the clock line is held low before the request (120 µs at 25 MHz).
- `FIRST_EDGE_TIMEOUT`, 375000: max cycles from clock release to the first device falling edge (15 ms).
- `EDGE_TIMEOUT`, 50000: max cycles between consecutive falling edges, and for the final line release (2 ms).
- `clk25`  in  1  system clock, 25 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `tx_data`  in  8  byte to send; sampled on accept.
- `tx_valid`  in  1  request; accepted when `tx_valid & tx_ready`.
- `tx_ready`  out  1  high only in IDLE.
- `tx_done`  out  1  1-cycle pulse: byte acknowledged and lines released.
- `tx_error`  out  1  1-cycle pulse: timeout or missing ACK.
- `busy`  out  1  high in every state except IDLE.
- `ps2_clk_in`, `ps2_din_in`  in  1  raw pin levels, asynchronous.
- `ps2_clk_oe`, `ps2_din_oe`  out  1  1 = drive pin low, 0 = release.

## Operation
- Inputs pass through a 2-FF synchronizer and a previous-value register. Falling edge = prev & ~cur.
- Parity: odd, `par = ~^data`.
- The 11-bit frame is {stop=1, par, data[7:0], start=0}, shifted LSB-first.
- `ps2_din_oe = ~current_bit` while driving. The stop bit releases data.
- IDLE: both oe = 0 and `tx_ready` = 1. On accept, latch data and parity and go to INHIBIT.
- INHIBIT: `ps2_clk_oe` = 1 for INHIBIT_CYCLES cycles, then go to REQ.
- REQ: one cycle with `ps2_clk_oe` = 1 and `ps2_din_oe` = 1 (start bit). Then go to WAIT_FIRST.
- WAIT_FIRST: clock released, data held low, timer = FIRST_EDGE_TIMEOUT.
  - The first falling edge presents data[0] and loads bit count 1. Go to SHIFT.
- SHIFT: each falling edge presents the next bit: data[1..7], parity, then stop.
  - The 10th falling edge releases data. Go to ACK.
  - The timer reloads to EDGE_TIMEOUT on every edge.
- ACK: at the 11th falling edge, sample synced data.
  - 0: go to RELEASE.
  - 1: `tx_error`, go to IDLE.
- RELEASE: wait until synced clk and data are both 1. Then pulse `tx_done` and go to IDLE.
- A timeout in any waiting state releases both lines, pulses `tx_error` and returns to IDLE.
- `tx_valid` while busy is ignored. The held request is accepted in the next IDLE cycle.
- The host inhibit overrides any device-to-host frame in progress. The receiver discards its partial frame while `busy`.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_din_oe`=0, `tx_ready`=1, `tx_done`=0, `tx_error`=0, `busy`=0, state IDLE. Reset takes effect asynchronously and releases the lines immediately, mid-frame included.
- Accept in cycle N: `ps2_clk_oe`=1 and `busy`=1 from N+1.
- `ps2_din_oe` asserts at N+1+INHIBIT_CYCLES.
- `ps2_clk_oe` deasserts one cycle later.
- A pin falling edge is detected 3 cycles later. `ps2_din_oe` updates on the following cycle.
- This is far inside the device's ~40 µs clock-low window.
- `tx_done` and `tx_error` are mutually exclusive, 1 cycle each. `tx_ready` rises the cycle after either pulse.
- Timer: 19-bit down-counter. Timeout fires on the cycle the counter reaches 0 with no edge. An edge on that same cycle wins.

## Structure
- Shared package/header `ps2_defs`:
  - state encodings for IDLE, INHIBIT, REQ, WAIT_FIRST, SHIFT, ACK, RELEASE;
  - a `ps2_odd_parity` function;
  - command constants CMD_RESET=8'hFF, CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4.
- One sub-module, `ps2_line_sync`: 2-FF synchronizer plus falling-edge detector for one line. Instantiate it twice here; the receiver reuses it.

## Test plan
The bench runs with INHIBIT_CYCLES=100, FIRST_EDGE_TIMEOUT=2000 and EDGE_TIMEOUT=500. The device model clocks at ~12 kHz-equivalent scaled period 200 cycles.
- Send 0xED; device model ACKs → bits sampled on rising edges are 0,1,0,1,1,0,1,1,1,1,1. `tx_done` pulses once, `tx_error` stays 0, both oe = 0 after.
- Send 0xF4 → parity bit 0. Also check `ps2_clk_oe` is held exactly 100 cycles before `ps2_din_oe` asserts.
- Device never clocks after the request → `tx_error` exactly 2000 cycles after clock release. Lines released and `tx_ready`=1.
- Device leaves data high at the 11th clock (no ACK) → `tx_error`, no `tx_done`.
- Device stops clocking after bit 4 → `tx_error` 500 cycles after the last edge.
- Assert `rst_n`=0 mid-SHIFT → both oe drop with no clock edge. After release, 0xFF transmits normally with parity 1. A second `tx_valid` during busy is not accepted until IDLE.
